// File: rtl/intr_ctrl.sv
// intr_ctrl: edge-detecting, fixed-priority interrupt controller driving INTR/INT_VEC with an ACK/DONE handshake.
// Optional build macro INTR_SYNC_EN inserts a two-flop synchronizer on irq_in ahead of edge detection.
module intr_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int VEC_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               int_ack,
  input  logic               int_done,
  output logic               intr,
  output logic [VEC_W-1:0]   int_vec,
  output logic               int_busy,
  output logic [NUM_SRC-1:0] irq_pend,
  output logic [NUM_SRC-1:0] irq_ovr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [NUM_SRC-1:0] irq_s;
  logic [NUM_SRC-1:0] irq_prev_r;
  logic [NUM_SRC-1:0] rise_s;
  logic [NUM_SRC-1:0] elig_s;
  logic [NUM_SRC-1:0] clr_s;
  logic [VEC_W-1:0]   win_s;
  logic [VEC_W-1:0]   vec_nxt_s;
  logic               ack_clr_s;

`ifdef INTR_SYNC_EN
  logic [NUM_SRC-1:0] sync1_r;
  logic [NUM_SRC-1:0] sync2_r;

  // Two-flop synchronizer for asynchronous peripheral lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= {NUM_SRC{1'b0}};
      sync2_r <= {NUM_SRC{1'b0}};
    end else begin
      sync1_r <= irq_in;
      sync2_r <= sync1_r;
    end
  end
  assign irq_s = sync2_r;
`else
  assign irq_s = irq_in;
`endif

  assign rise_s = irq_s & ~irq_prev_r;
  assign elig_s = irq_pend & irq_mask;
  // One-hot clear of the acknowledged source; applied only on the ACK edge
  assign clr_s  = ack_clr_s ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << int_vec) : {NUM_SRC{1'b0}};

  // Fixed-priority arbiter: scanning downward leaves the lowest eligible index
  always_comb begin
    win_s = {VEC_W{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      win_s = elig_s[i] ? VEC_W'(i) : win_s;
    end
  end

  // Next-state, vector latch and ACK-clear decode
  always_comb begin
    state_nxt_s = state_r;
    vec_nxt_s   = int_vec;
    ack_clr_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (|elig_s) begin
          state_nxt_s = REQ;
          vec_nxt_s   = win_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_nxt_s = SERVICE;
          ack_clr_s   = 1'b1;
        end else begin
          state_nxt_s = REQ;
        end
      end
      SERVICE: begin
        if (int_done) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SERVICE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      int_vec  <= {VEC_W{1'b0}};
      intr     <= 1'b0;
      int_busy <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      int_vec  <= vec_nxt_s;
      intr     <= (state_nxt_s == REQ);
      int_busy <= (state_nxt_s == SERVICE);
    end
  end

  // Edge history, pending and overrun; a fresh rise beats the ACK clear on pending, not on overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev_r <= {NUM_SRC{1'b0}};
      irq_pend   <= {NUM_SRC{1'b0}};
      irq_ovr    <= {NUM_SRC{1'b0}};
    end else begin
      irq_prev_r <= irq_s;
      irq_pend   <= (irq_pend & ~clr_s) | rise_s;
      irq_ovr    <= (irq_ovr | (rise_s & irq_pend)) & ~clr_s;
    end
  end

endmodule
